// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - state encoding and key index constants for counter_seq_ctrl
package counter_seq_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_RUN   = 2'd1;
    localparam seq_state_t ST_PAUSE = 2'd2;
    localparam seq_state_t ST_DONE  = 2'd3;

    localparam int K_START = 0;
    localparam int K_STEP  = 1;
    localparam int K_CLEAR = 2;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-FF sync, debounce (COUNTER_SEQ_DEBOUNCE_EN), press pulse
module key_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

`ifdef COUNTER_SEQ_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [CW-1:0] db_cnt;

    // The accepted level only moves after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            level  <= 1'b1;
            db_cnt <= '0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    localparam int unused_db_cycles = DB_CYCLES;

    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign press = level_q & ~level;

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - run/pause/step/clear sequencer for the modulo-M counter (COUNTER_SEQ_DEBOUNCE_EN)
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int M         = 8,
    parameter int CNT_W     = 8,
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key_n,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [1:0]       state,
    output logic             running,
    output logic             done
);

    localparam int PW = $clog2(DIV);

    logic          ev_start;
    logic          ev_step;
    logic          ev_clear;
    logic          unused_key;
    seq_state_t    state_q;
    seq_state_t    state_next;
    logic          en_next;
    logic          clr_next;
    logic [PW-1:0] presc;
    logic          run_adv;
    logic          tick;
    logic          at_tc;

    assign unused_key = key_n[3];

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_start (
        .clk(clk), .rst(rst), .key_n(key_n[K_START]), .press(ev_start)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_step (
        .clk(clk), .rst(rst), .key_n(key_n[K_STEP]), .press(ev_step)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_clear (
        .clk(clk), .rst(rst), .key_n(key_n[K_CLEAR]), .press(ev_clear)
    );

    // A start or clear event pre-empts the prescaler for that cycle, so no tick is lost into PAUSE.
    assign run_adv = (state_q == ST_RUN) && !ev_clear && !ev_start;
    assign tick    = run_adv && (presc == PW'(DIV - 1));
    assign at_tc   = (cnt_value == CNT_W'(M - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        if (ev_clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (ev_start) state_next = ST_RUN;
                ST_RUN: begin
                    if (ev_start)                    state_next = ST_PAUSE;
                    else if (tick && oneshot && at_tc) state_next = ST_DONE;
                end
                ST_PAUSE: if (ev_start) state_next = ST_RUN;
                ST_DONE:  if (ev_start) state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        en_next  = 1'b0;
        clr_next = 1'b0;
        if (ev_clear) begin
            clr_next = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: en_next  = ev_step && !ev_start;
                ST_RUN:            en_next  = tick && !(oneshot && at_tc);
                ST_DONE:           clr_next = ev_start;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b1;
        end else begin
            cnt_en  <= en_next & ~clr_next;
            cnt_clr <= clr_next;
        end
    end

    // Held at zero outside RUN/PAUSE, so entering RUN from IDLE or DONE always starts a full period.
    always_ff @(posedge clk) begin
        if (rst || ev_clear || state_q == ST_IDLE || state_q == ST_DONE) begin
            presc <= '0;
        end else if (run_adv) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    assign state   = state_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - directed bench for counter_seq_ctrl (COUNTER_SEQ_DEBOUNCE_EN aware)
module tb_counter_seq_ctrl;

    localparam int M     = 8;
    localparam int CNT_W = 8;
    localparam int DIV   = 4;
    localparam int DB    = 3;
`ifdef COUNTER_SEQ_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       key_n;
    logic             oneshot;
    logic [CNT_W-1:0] cv = '0;
    logic             cnt_en;
    logic             cnt_clr;
    logic [1:0]       state;
    logic             running;
    logic             done;

    int n_vec  = 0;
    int n_err  = 0;
    int en_cnt = 0;
    int e0;
    logic [11:0] pat;

    counter_seq_ctrl #(.M(M), .CNT_W(CNT_W), .DIV(DIV), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .oneshot(oneshot), .cnt_value(cv),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .state(state), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // Stand-in for the modulo-M counter that this controller drives.
    always @(posedge clk) begin
        if (cnt_clr)     cv <= '0;
        else if (cnt_en) cv <= (cv == CNT_W'(M - 1)) ? '0 : cv + 1'b1;
    end

    always @(negedge clk) if (cnt_en === 1'b1) en_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic press(input logic [3:0] mask);
        key_n = ~mask;
        cyc(LAT);
        key_n = 4'hF;
    endtask

    task automatic settle();
        cyc(LAT + 1);
    endtask

    initial begin
        rst = 1'b1; key_n = 4'hF; oneshot = 1'b0;
        cyc(2);
        check("rst_clr", cnt_clr, 1);
        check("rst_state", state, 0);
        check("rst_en", cnt_en, 0);
        rst = 1'b0;
        cyc(1);
        check("rel_clr", cnt_clr, 0);
        check("rel_state", state, 0);

        key_n = 4'b1110;
        cyc(LAT - 1);
        check("start_pre", state, 0);
        cyc(1);
        check("start_lat", state, 1);
        check("running", running, 1);
        key_n = 4'hF;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            pat[k] = cnt_en;
        end
        check("run_pattern", pat, 12'h888);

        press(4'b0001);
        check("pause_state", state, 2);
        e0 = en_cnt;
        cyc(12);
        check("pause_noen", en_cnt - e0, 0);

        e0 = en_cnt;
        repeat (3) begin
            press(4'b0010);
            settle();
        end
        check("step3", en_cnt - e0, 3);
        check("step_state", state, 2);

`ifdef COUNTER_SEQ_DEBOUNCE_EN
        e0 = en_cnt;
        for (int i = 0; i < 2; i++) begin
            repeat (3) begin
                key_n[i] = 1'b0;
                cyc(1);
                key_n[i] = 1'b1;
                cyc(3);
            end
        end
        settle();
        check("bounce_noen", en_cnt - e0, 0);
        check("bounce_state", state, 2);
`endif

        press(4'b0100);
        check("clr_pulse", cnt_clr, 1);
        check("clr_state", state, 0);
        settle();
        check("cv_clr", cv, 0);

        oneshot = 1'b1;
        press(4'b0001);
        check("os_run", state, 1);
        e0 = en_cnt;
        for (int i = 0; i < 60 && done !== 1'b1; i++) cyc(1);
        check("os_done", done, 1);
        check("os_pulses", en_cnt - e0, 7);
        check("os_cv", cv, 7);
        settle();
        check("done_noen", en_cnt - e0, 7);
        check("done_state", state, 3);
        press(4'b0001);
        check("restart_clr", cnt_clr, 1);
        check("restart_en", cnt_en, 0);
        check("restart_state", state, 1);
        cyc(1);
        check("restart_cv", cv, 0);
        oneshot = 1'b0;
        settle();

        press(4'b0101);
        check("simul_state", state, 0);
        check("simul_clr", cnt_clr, 1);
        check("simul_en", cnt_en, 0);
        settle();

        press(4'b0011);
        check("ss_state", state, 1);
        check("ss_en", cnt_en, 0);
        settle();
        cyc(2);
        rst = 1'b1;
        cyc(1);
        check("mrst_state", state, 0);
        check("mrst_clr", cnt_clr, 1);
        check("mrst_en", cnt_en, 0);
        check("mrst_run", running, 0);
        rst = 1'b0;
        cyc(1);
        check("mrst_rel_clr", cnt_clr, 0);
        check("mrst_rel_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
